// File: rtl/elevator_ctrl.sv
// Collective-SCAN elevator car/door scheduler; all outputs registered, requests act one edge after latching.
// No backpressure: calls are absorbed every edge, travel/dwell timed by free-running clear-when-idle counters.
module elevator_ctrl #(
    parameter int pFLOORS     = 4,
    parameter int pFLOOR_BITS = 2,
    parameter int pMOVE_BITS  = 5,
    parameter int pDOOR_BITS  = 6
) (
    input  logic                   i_clock,
    input  logic                   i_rst_n,
    input  logic [pFLOORS-1:0]     i_req,
    input  logic                   i_door_hold,
    output logic [pFLOOR_BITS-1:0] o_floor,
    output logic                   o_moving_up,
    output logic                   o_moving_down,
    output logic                   o_door_open,
    output logic                   o_arrive,
    output logic [pFLOORS-1:0]     o_pending
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    state_t                   state, state_nxt;
    logic                     dir, dir_nxt;
    logic [pFLOOR_BITS-1:0]   floor_nxt;
    logic [pFLOORS-1:0]       clr;
    logic                     arrive_nxt;
    logic [pMOVE_BITS-1:0]    move_cnt;
    logic [pDOOR_BITS-1:0]    door_cnt;

    logic [pFLOOR_BITS-1:0]   floor_up, floor_dn;
    logic                     here, above, below;
    logic                     up_above, up_below, dn_above, dn_below;
    logic                     go_any, go_up;
    logic                     moving, move_done, door_done;

    function automatic logic any_above(input logic [pFLOORS-1:0] p,
                                       input logic [pFLOOR_BITS-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < pFLOORS; i++)
            if (i > int'(f) && p[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [pFLOORS-1:0] p,
                                       input logic [pFLOOR_BITS-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < pFLOORS; i++)
            if (i < int'(f) && p[i]) r = 1'b1;
        return r;
    endfunction

    // Request terminology relative to the current floor and to the floor a step lands on.
    always_comb begin
        floor_up  = o_floor + 1'b1;
        floor_dn  = o_floor - 1'b1;
        here      = o_pending[o_floor];
        above     = any_above(o_pending, o_floor);
        below     = any_below(o_pending, o_floor);
        up_above  = any_above(o_pending, floor_up);
        up_below  = any_below(o_pending, floor_up);
        dn_above  = any_above(o_pending, floor_dn);
        dn_below  = any_below(o_pending, floor_dn);
        go_any    = above | below;
        go_up     = (above && below) ? (dir == DIR_UP) : above;
        moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
        move_done = moving && (&move_cnt);
        door_done = (state == DOOR_OPEN) && (&door_cnt) && !i_door_hold;
    end

    // State register
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and serve decisions
    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir;
        floor_nxt  = o_floor;
        clr        = '0;
        arrive_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (here) begin
                    state_nxt    = DOOR_OPEN;
                    clr[o_floor] = 1'b1;
                end else if (go_any) begin
                    state_nxt = go_up ? MOVE_UP : MOVE_DOWN;
                    dir_nxt   = go_up ? DIR_UP : DIR_DOWN;
                end
            end
            MOVE_UP: begin
                if (move_done) begin
                    floor_nxt  = floor_up;
                    arrive_nxt = 1'b1;
                    if (o_pending[floor_up]) begin
                        state_nxt     = DOOR_OPEN;
                        clr[floor_up] = 1'b1;
                    end else if (up_above) begin
                        state_nxt = MOVE_UP;
                    end else if (up_below) begin
                        state_nxt = MOVE_DOWN;
                        dir_nxt   = DIR_DOWN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (move_done) begin
                    floor_nxt  = floor_dn;
                    arrive_nxt = 1'b1;
                    if (o_pending[floor_dn]) begin
                        state_nxt     = DOOR_OPEN;
                        clr[floor_dn] = 1'b1;
                    end else if (dn_below) begin
                        state_nxt = MOVE_DOWN;
                    end else if (dn_above) begin
                        state_nxt = MOVE_UP;
                        dir_nxt   = DIR_UP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                // Calls for the open floor are swallowed while the door is open.
                clr[o_floor] = 1'b1;
                if (door_done) begin
                    if (go_any) begin
                        state_nxt = go_up ? MOVE_UP : MOVE_DOWN;
                        dir_nxt   = go_up ? DIR_UP : DIR_DOWN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_floor   <= '0;
            o_pending <= '0;
            o_arrive  <= 1'b0;
            dir       <= DIR_UP;
            move_cnt  <= '0;
            door_cnt  <= '0;
        end else begin
            o_floor   <= floor_nxt;
            o_pending <= (o_pending | i_req) & ~clr;
            o_arrive  <= arrive_nxt;
            dir       <= dir_nxt;
            move_cnt  <= moving ? move_cnt + 1'b1 : '0;
            door_cnt  <= (state == DOOR_OPEN && !i_door_hold) ? door_cnt + 1'b1 : '0;
        end
    end

    // Motion/door flags are pure decodes of the state register
    always_comb begin
        o_moving_up   = (state == MOVE_UP);
        o_moving_down = (state == MOVE_DOWN);
        o_door_open   = (state == DOOR_OPEN);
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with 8-cycle travel and 16-cycle dwell.
module tb_elevator_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       hold;
    logic [1:0] o_floor;
    logic       o_moving_up, o_moving_down, o_door_open, o_arrive;
    logic [3:0] o_pending;

    int checks      = 0;
    int failures    = 0;
    int arrive_cnt  = 0;
    int a0;

    elevator_ctrl #(
        .pFLOORS     (4),
        .pFLOOR_BITS (2),
        .pMOVE_BITS  (3),
        .pDOOR_BITS  (4)
    ) dut (
        .i_clock       (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_door_hold   (hold),
        .o_floor       (o_floor),
        .o_moving_up   (o_moving_up),
        .o_moving_down (o_moving_down),
        .o_door_open   (o_door_open),
        .o_arrive      (o_arrive),
        .o_pending     (o_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (o_arrive === 1'b1) arrive_cnt <= arrive_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] fl, input logic up,
                            input logic dn, input logic door, input logic [3:0] pend);
        chk({tag, "_floor"}, 32'(o_floor), 32'(fl));
        chk({tag, "_up"},    32'(o_moving_up), 32'(up));
        chk({tag, "_down"},  32'(o_moving_down), 32'(dn));
        chk({tag, "_door"},  32'(o_door_open), 32'(door));
        chk({tag, "_pend"},  32'(o_pending), 32'(pend));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        hold  = 1'b0;

        // 1: reset state, then idle
        tick(2);
        chk_outs("t1_rst", 2'd0, 0, 0, 0, 4'b0000);
        chk("t1_rst_arrive", 32'(o_arrive), 32'd0);
        rst_n = 1'b1;
        tick(10);
        chk_outs("t1_idle", 2'd0, 0, 0, 0, 4'b0000);
        chk("t1_idle_arrive", 32'(o_arrive), 32'd0);

        // 2: single call to floor 2
        a0  = arrive_cnt;
        req = 4'b0100;
        tick(1);
        req = '0;
        chk_outs("t2_latch", 2'd0, 0, 0, 0, 4'b0100);
        tick(1);
        chk_outs("t2_go", 2'd0, 1, 0, 0, 4'b0100);
        tick(7);
        chk("t2_pre_step_floor", 32'(o_floor), 32'd0);
        chk("t2_pre_step_arrive", 32'(o_arrive), 32'd0);
        tick(1);
        chk_outs("t2_f1", 2'd1, 1, 0, 0, 4'b0100);
        chk("t2_f1_arrive", 32'(o_arrive), 32'd1);
        tick(1);
        chk("t2_f1_arrive_off", 32'(o_arrive), 32'd0);
        tick(7);
        chk_outs("t2_f2", 2'd2, 0, 0, 1, 4'b0000);
        chk("t2_f2_arrive", 32'(o_arrive), 32'd1);
        tick(15);
        chk("t2_door_last", 32'(o_door_open), 32'd1);
        tick(1);
        chk_outs("t2_idle", 2'd2, 0, 0, 0, 4'b0000);
        chk("t2_arrivals", 32'(arrive_cnt - a0), 32'd2);

        // 3: call at the current floor only opens the door
        do_reset();
        a0  = arrive_cnt;
        req = 4'b0001;
        tick(1);
        req = '0;
        chk_outs("t3_latch", 2'd0, 0, 0, 0, 4'b0001);
        tick(1);
        chk_outs("t3_open", 2'd0, 0, 0, 1, 4'b0000);
        tick(15);
        chk("t3_door_last", 32'(o_door_open), 32'd1);
        tick(1);
        chk_outs("t3_idle", 2'd0, 0, 0, 0, 4'b0000);
        chk("t3_arrivals", 32'(arrive_cnt - a0), 32'd0);

        // 4: call behind the car waits for the sweep to finish
        req = 4'b1000;
        tick(1);
        req = '0;
        tick(1);
        chk("t4_go_up", 32'(o_moving_up), 32'd1);
        tick(8);
        chk("t4_f1", 32'(o_floor), 32'd1);
        req = 4'b0001;
        tick(1);
        req = '0;
        chk_outs("t4_latch0", 2'd1, 1, 0, 0, 4'b1001);
        tick(15);
        chk_outs("t4_f3_open", 2'd3, 0, 0, 1, 4'b0001);
        tick(16);
        chk_outs("t4_turn", 2'd3, 0, 1, 0, 4'b0001);
        a0 = arrive_cnt;
        tick(8);
        chk_outs("t4_f2", 2'd2, 0, 1, 0, 4'b0001);
        tick(16);
        chk_outs("t4_f0_open", 2'd0, 0, 0, 1, 4'b0000);
        chk("t4_down_arrivals", 32'(arrive_cnt - a0), 32'd3);
        tick(16);
        chk_outs("t4_idle", 2'd0, 0, 0, 0, 4'b0000);

        // 5: door hold extends dwell
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(17);
        chk_outs("t5_open", 2'd2, 0, 0, 1, 4'b0000);
        hold = 1'b1;
        tick(20);
        chk("t5_held", 32'(o_door_open), 32'd1);
        hold = 1'b0;
        tick(15);
        chk("t5_dwell_last", 32'(o_door_open), 32'd1);
        tick(1);
        chk_outs("t5_closed", 2'd2, 0, 0, 0, 4'b0000);

        // 6: async reset while moving down with calls pending
        req = 4'b0010;
        tick(1);
        req = '0;
        tick(1);
        chk("t6_go_down", 32'(o_moving_down), 32'd1);
        req = 4'b1000;
        tick(1);
        req = '0;
        tick(1);
        chk_outs("t6_pre", 2'd2, 0, 1, 0, 4'b1010);
        rst_n = 1'b0;
        #1;
        chk_outs("t6_async", 2'd0, 0, 0, 0, 4'b0000);
        chk("t6_async_arrive", 32'(o_arrive), 32'd0);
        tick(2);
        rst_n = 1'b1;
        a0 = arrive_cnt;
        tick(10);
        chk_outs("t6_after", 2'd0, 0, 0, 0, 4'b0000);
        chk("t6_arrivals", 32'(arrive_cnt - a0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
